pe_lin_feeder: RTL and testbench
================================

Name: pe_lin_feeder

Overview:
- Source-side sequencer for the 4-PE linear systolic chain.
- Holds four stationary 8-bit weights, loaded over a simple write port.
- Accepts an activation vector over a valid/ready stream and drives the chain's fire/activation/weight inputs one beat per accepted activation.
- After the last beat, waits out the chain's propagation depth, then pulses res_valid so the result consumer can sample o1..o4.

Parameters:
- N_PE, 4, number of PEs in the chain; sets weight register count and drain depth.
- DATA_W, 8, activation and weight width.
- DRAIN_CYC, 4, cycles from the last fire until the chain outputs are settled (= N_PE).
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a vector; honoured only in IDLE.
- abort  in  1  return to IDLE from any state.
- w_wr  in  1  weight write strobe.
- w_idx  in  2  weight index, 0..N_PE-1.
- w_data  in  DATA_W  weight value.
- w_busy  out  1  high when not in IDLE; weight writes are ignored while high.
- s_valid  in  1  activation beat valid.
- s_ready  out  1  activation beat ready.
- s_data  in  DATA_W  activation value.
- s_last  in  1  marks the final beat of a vector.
- fire  out  1  to chain fire input.
- in_a  out  DATA_W  to chain activation input.
- in_w1..in_w4  out  DATA_W each  to chain weight inputs; equal to weight regs 0..3.
- res_valid  out  1  one-cycle pulse; chain outputs are valid this cycle.
- beats  out  CNT_W  beats accepted in the current or most recent vector.

Behaviour:
- Reset values: state=IDLE; fire=0, in_a=0, weight regs=0, s_ready=0, res_valid=0, beats=0, w_busy=0.
- States and transitions:
  - IDLE: s_ready=0; w_busy=0.
    - w_wr writes w[w_idx]<=w_data; new value appears on in_wN the next cycle.
    - start -> STREAM, beats<=0.
    - start and w_wr in the same cycle: the write is taken, then STREAM begins.
  - STREAM: s_ready=1.
    - Handshake: a beat is accepted when s_valid&&s_ready.
    - Accepted beat: next cycle fire=1 and in_a=s_data. Latency is 1 cycle.
    - Accepted beat increments beats, saturating at all-ones.
    - No beat accepted: fire=0 next cycle and in_a holds its last value.
    - Accepted beat with s_last=1 -> DRAIN, drain counter<=DRAIN_CYC-1.
    - s_last without s_valid is ignored.
  - DRAIN: s_ready=0, fire=0. The counter decrements each cycle; at 0 -> DONE.
  - DONE: res_valid=1 for exactly this cycle, then -> IDLE. beats holds until the next start.
- abort is checked first in every state: next cycle state=IDLE, fire=0, s_ready=0, res_valid=0.
  - Weights and beats are retained.
  - An abort coinciding with an s_last acceptance wins: no DRAIN, no res_valid.
- start outside IDLE is ignored.
- w_wr outside IDLE is ignored; weights never change mid-vector.
- A single-beat vector (first beat has s_last) is legal: fire for 1 cycle, then DRAIN.
- Timing from last fire to res_valid:
  - Last fire at cycle T.
  - DRAIN occupies T..T+DRAIN_CYC-1.
  - res_valid is high at cycle T+DRAIN_CYC.
- rst mid-operation returns every output to its reset value on the next edge, including the weights.

Decomposition:
- Package pe_lin_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN, DONE);
  - default N_PE/DATA_W constants;
  - a localparam for DRAIN_CYC derived from N_PE.
- No sub-module. The weight register bank is a trivial array and stays inline.

Test Plan:
- Weight load:
  - Stimulus: in IDLE, write w_idx 0..3 with 0x11,0x22,0x33,0x44.
  - Response: in_w1..in_w4 show these values one cycle after each write.
  - Stimulus: write 0x55 to idx 0 during STREAM.
  - Response: in_w1 stays 0x11.
- Basic vector:
  - Stimulus: start, then beats 0x01,0x02,0x03 with s_valid held high and s_last on the third.
  - Response: fire=1 for 3 consecutive cycles with in_a=1,2,3; fire=0 afterwards; res_valid exactly 4 cycles after the last fire cycle; beats=3.
- Backpressure/gaps:
  - Stimulus: s_valid pattern 1,0,0,1(last) with data 0xA0 then 0xA1.
  - Response: fire pattern 1,0,0,1 (shifted 1 cycle); in_a holds 0xA0 through the gap; beats=2.
- Single beat and start ignore:
  - Stimulus: start, one beat 0x7F with s_last.
  - Response: one fire, res_valid 4 cycles later.
  - Stimulus: start asserted during DRAIN.
  - Response: no new STREAM after DONE; FSM idles.
- Abort/reset:
  - Stimulus: abort in the same cycle as an s_last acceptance.
  - Response: no res_valid; IDLE next cycle; weights intact.
  - Stimulus: rst during STREAM.
  - Response: all outputs 0 next cycle, including in_w1..in_w4.
- Counter saturation:
  - Stimulus: 65540 beats with s_valid held high, no s_last.
  - Response: beats=0xFFFF; fire continues every cycle.

Source files
------------

// File: rtl/pe_lin_pkg.sv
// Shared types and default sizing for the linear systolic chain feeder.
package pe_lin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int N_PE_DEF      = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int CNT_W_DEF     = 16;
  // Results settle one cycle per PE after the last fire.
  localparam int DRAIN_CYC_DEF = N_PE_DEF;

endpackage

// File: rtl/pe_lin_feeder.sv
// Source-side sequencer for the 4-PE linear chain: stationary weights,
// activation stream to fire/in_a, and a res_valid pulse once the chain drains.
module pe_lin_feeder
  import pe_lin_pkg::*;
#(
  parameter int N_PE      = N_PE_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DRAIN_CYC = N_PE,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_w_wr,
  input  logic [1:0]        i_w_idx,
  input  logic [DATA_W-1:0] i_w_data,
  output logic              o_w_busy,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  output logic              o_fire,
  output logic [DATA_W-1:0] o_in_a,
  output logic [DATA_W-1:0] o_in_w1,
  output logic [DATA_W-1:0] o_in_w2,
  output logic [DATA_W-1:0] o_in_w3,
  output logic [DATA_W-1:0] o_in_w4,
  output logic              o_res_valid,
  output logic [CNT_W-1:0]  o_beats
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e              r_state;
  logic [DATA_W-1:0]   r_w [N_PE];
  logic [DATA_W-1:0]   r_in_a;
  logic [CNT_W-1:0]    r_beats;
  logic [DRAIN_W-1:0]  r_drain;
  logic                r_fire;
  logic                r_s_ready;
  logic                r_res_valid;
  logic                r_w_busy;
  logic                w_accept;

  assign w_accept = i_s_valid && r_s_ready;

  // Sequencer FSM with registered outputs; abort overrides every state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_in_a      <= '0;
      r_beats     <= '0;
      r_drain     <= '0;
      r_fire      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_w_busy    <= 1'b0;
      for (int i = 0; i < N_PE; i++) r_w[i] <= '0;
    end else if (i_abort) begin
      r_state     <= ST_IDLE;
      r_fire      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_w_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fire      <= 1'b0;
          r_res_valid <= 1'b0;
          if (i_w_wr) r_w[i_w_idx] <= i_w_data;
          if (i_start) begin
            r_state   <= ST_STREAM;
            r_beats   <= '0;
            r_s_ready <= 1'b1;
            r_w_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          r_fire <= w_accept;
          if (w_accept) begin
            r_in_a <= i_s_data;
            if (r_beats != {CNT_W{1'b1}}) r_beats <= r_beats + CNT_W'(1);
            if (i_s_last) begin
              r_state   <= ST_DRAIN;
              r_drain   <= DRAIN_W'(DRAIN_CYC - 1);
              r_s_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          r_fire <= 1'b0;
          if (r_drain == '0) begin
            r_state     <= ST_DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_drain <= r_drain - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_res_valid <= 1'b0;
          r_w_busy    <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_fire      <= 1'b0;
          r_s_ready   <= 1'b0;
          r_res_valid <= 1'b0;
          r_w_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_w_busy    = r_w_busy;
  assign o_s_ready   = r_s_ready;
  assign o_fire      = r_fire;
  assign o_in_a      = r_in_a;
  assign o_res_valid = r_res_valid;
  assign o_beats     = r_beats;
  assign o_in_w1     = r_w[0];
  assign o_in_w2     = r_w[1];
  assign o_in_w3     = r_w[2];
  assign o_in_w4     = r_w[3];

endmodule

// File: tb/tb_pe_lin_feeder.sv
// Directed self-checking bench for pe_lin_feeder.
module tb_pe_lin_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        w_wr;
  logic [1:0]  w_idx;
  logic [7:0]  w_data;
  logic        w_busy;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        fire;
  logic [7:0]  in_a;
  logic [7:0]  in_w1, in_w2, in_w3, in_w4;
  logic        res_valid;
  logic [15:0] beats;

  int n_checks;
  int n_fail;

  pe_lin_feeder dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_w_wr(w_wr), .i_w_idx(w_idx), .i_w_data(w_data), .o_w_busy(w_busy),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_last(s_last),
    .o_fire(fire), .o_in_a(in_a),
    .o_in_w1(in_w1), .o_in_w2(in_w2), .o_in_w3(in_w3), .o_in_w4(in_w4),
    .o_res_valid(res_valid), .o_beats(beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain_check(input string tag, input logic [15:0] exp_beats);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk({tag, "_fire"}, 32'(fire), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    chk({tag, "_beats"}, 32'(beats), 32'(exp_beats));
    cyc();
    chk({tag, "_idle_busy"}, 32'(w_busy), 32'd0);
    chk({tag, "_res_low"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] wexp [4];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; w_wr = 1'b0; w_idx = 2'd0;
    w_data = 8'd0; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
    wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;

    // reset state
    cyc(); cyc();
    chk("rst_fire", 32'(fire), 32'd0);
    chk("rst_in_a", 32'(in_a), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_res", 32'(res_valid), 32'd0);
    chk("rst_beats", 32'(beats), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_w", {in_w1, in_w2, in_w3, in_w4}, 32'd0);
    rst = 1'b0;
    cyc();

    // weight load in IDLE
    for (int i = 0; i < 4; i++) begin
      w_wr = 1'b1; w_idx = 2'(i); w_data = wexp[i];
      cyc();
      chk("wload", {in_w1, in_w2, in_w3, in_w4} >> (8 * (3 - i)) & 32'hFF, 32'(wexp[i]));
    end
    w_wr = 1'b0;
    chk("wload_all", {in_w1, in_w2, in_w3, in_w4}, 32'h11223344);

    // basic vector 1,2,3 with a blocked weight write mid-stream
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("basic_ready", 32'(s_ready), 32'd1);
    chk("basic_busy", 32'(w_busy), 32'd1);
    s_valid = 1'b1; s_data = 8'h01;
    cyc();
    chk("basic_fire1", {fire, in_a}, {23'd0, 1'b1, 8'h01});
    s_data = 8'h02; w_wr = 1'b1; w_idx = 2'd0; w_data = 8'h55;
    cyc();
    w_wr = 1'b0;
    chk("basic_fire2", {fire, in_a}, {23'd0, 1'b1, 8'h02});
    s_data = 8'h03; s_last = 1'b1;
    cyc();
    chk("wr_blocked", 32'(in_w1), 32'h11);
    chk("basic_fire3", {fire, in_a}, {23'd0, 1'b1, 8'h03});
    chk("basic_ready_off", 32'(s_ready), 32'd0);
    s_valid = 1'b0; s_last = 1'b0;
    drain_check("basic", 16'd3);

    // backpressure gaps: valid 1,0,0,1(last)
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'hA0;
    cyc();
    chk("gap_fire1", {fire, in_a}, {23'd0, 1'b1, 8'hA0});
    s_valid = 1'b0; s_data = 8'hEE; s_last = 1'b1;
    cyc();
    chk("gap_fire2", {fire, in_a}, {23'd0, 1'b0, 8'hA0});
    chk("gap_last_ignored", 32'(s_ready), 32'd1);
    s_last = 1'b0;
    cyc();
    chk("gap_fire3", {fire, in_a}, {23'd0, 1'b0, 8'hA0});
    s_valid = 1'b1; s_data = 8'hA1; s_last = 1'b1;
    cyc();
    chk("gap_fire4", {fire, in_a}, {23'd0, 1'b1, 8'hA1});
    s_valid = 1'b0; s_last = 1'b0;
    drain_check("gap", 16'd2);

    // single beat, start held during DRAIN is ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h7F; s_last = 1'b1;
    cyc();
    chk("single_fire", {fire, in_a}, {23'd0, 1'b1, 8'h7F});
    s_valid = 1'b0; s_last = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 3) start = 1'b0;
      chk("single_res", 32'(res_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("single_idle", {w_busy, s_ready}, 32'd0);
    cyc();
    chk("single_still_idle", {w_busy, s_ready}, 32'd0);
    chk("single_beats", 32'(beats), 32'd1);

    // abort coinciding with s_last acceptance
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h10; s_last = 1'b1; abort = 1'b1;
    cyc();
    s_valid = 1'b0; s_last = 1'b0; abort = 1'b0;
    chk("abort_idle", {fire, w_busy, s_ready, res_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("abort_no_res", {w_busy, res_valid}, 32'd0);
    end
    chk("abort_weights", {in_w1, in_w2, in_w3, in_w4}, 32'h11223344);

    // synchronous reset mid-stream
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h33;
    cyc();
    chk("rst_pre_fire", 32'(fire), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; s_valid = 1'b0;
    chk("midrst_w", {in_w1, in_w2, in_w3, in_w4}, 32'd0);
    chk("midrst_ctl", {fire, s_ready, res_valid, w_busy}, 32'd0);
    chk("midrst_data", {in_a, beats}, 32'd0);
    cyc();

    // beat counter saturation
    start = 1'b1;
    cyc();
    start = 1'b0;
    s_valid = 1'b1;
    for (int n = 1; n <= 65540; n++) begin
      s_data = 8'(n);
      cyc();
      if (n == 65534) chk("sat_fffe", 32'(beats), 32'h0000FFFE);
      if (n == 65535) chk("sat_ffff", 32'(beats), 32'h0000FFFF);
    end
    chk("sat_hold", 32'(beats), 32'h0000FFFF);
    chk("sat_fire", {fire, in_a}, {23'd0, 1'b1, 8'h04});
    s_valid = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("sat_abort_beats", {w_busy, beats}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
